// File: rtl/lod_pkg.sv
// lod_pkg: shared state type, widths and segment-offset helper for lod_seg_locate.
package lod_pkg;
    typedef enum logic [1:0] {IDLE, SEARCH, DIV, OUT} state_t;
    localparam int POS_W     = 10;
    localparam int VAL_W     = 8;
    localparam int GAIN_W    = 12;
    localparam int RECIP_NUM = 4096;
    localparam int DIV_CYC   = 13;
    // Below the table clamps to 0, past the last node clamps to W-1, empty segment gives 0.
    function automatic logic [POS_W-1:0] seg_offset(input logic [POS_W-1:0] x, lo, hi, input logic last);
        seg_offset = (hi == lo || x < lo) ? '0 : (last && x >= hi) ? hi - lo - POS_W'(1) : x - lo;
    endfunction
endpackage

// File: rtl/lod_recip_div.sv
// lod_recip_div: restoring divider, q = floor(RECIP_NUM / w), one quotient bit per cycle.
// The first bit is produced on the start edge, so done pulses DIV_CYC-1 edges later.
module lod_recip_div
    import lod_pkg::*;
(
    input  logic               CLK,
    input  logic               RSTB,
    input  logic               start_i,
    input  logic [POS_W-1:0]   w_i,
    output logic               done_o,
    output logic [DIV_CYC-1:0] q_o
);
    localparam logic [DIV_CYC-1:0] NUM = DIV_CYC'(RECIP_NUM);
    logic [POS_W-1:0] w_q, rem_q, w, r;
    logic [POS_W:0] t;
    logic [DIV_CYC-1:0] num_q;
    logic [3:0] cnt_q;
    logic busy_q, ge;
    always_comb begin
        w  = start_i ? w_i : w_q;
        r  = start_i ? '0 : rem_q;
        t  = {r, start_i ? NUM[DIV_CYC-1] : num_q[DIV_CYC-1]};
        ge = t >= {1'b0, w};
    end
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            w_q    <= '0;
            rem_q  <= '0;
            num_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_o <= 1'b0;
            q_o    <= '0;
        end else begin
            done_o <= busy_q && cnt_q == 4'(DIV_CYC - 1);
            if (start_i || busy_q) begin
                w_q    <= w;
                rem_q  <= ge ? POS_W'(t - {1'b0, w}) : POS_W'(t);
                q_o    <= start_i ? {{(DIV_CYC-1){1'b0}}, ge} : {q_o[DIV_CYC-2:0], ge};
                num_q  <= (start_i ? NUM : num_q) << 1;
                cnt_q  <= start_i ? 4'd1 : cnt_q + 4'd1;
                busy_q <= start_i || cnt_q != 4'(DIV_CYC - 1);
            end
        end
    end
endmodule

// File: rtl/lod_seg_locate.sv
// lod_seg_locate: linear-scan segment finder with reciprocal gain for the LOD XY interpolator.
// Define LOD_SEG_REUSE_EN to cache the last segment and bypass SEARCH/DIV on a hit.
module lod_seg_locate
    import lod_pkg::*;
#(
    parameter int NODE_NUM = 9,
    parameter int TBL_AW   = 4
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              TBL_WE,
    input  logic [TBL_AW-1:0] TBL_ADDR,
    input  logic [POS_W-1:0]  TBL_POS,
    input  logic [VAL_W-1:0]  TBL_VAL,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [POS_W-1:0]  IN_X,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [POS_W-1:0]  CURRENT,
    output logic [GAIN_W-1:0] GAIN,
    output logic [VAL_W-1:0]  LEFT_VALUE,
    output logic [VAL_W-1:0]  RIGHT_VALUE,
    output logic              BUSY
);
    localparam logic [TBL_AW-1:0] LAST_SEG = TBL_AW'(NODE_NUM - 2);
    state_t state_q;
    logic [POS_W-1:0] x_q, lo, hi, w, cur;
    logic [POS_W-1:0] pos_q [NODE_NUM];
    logic [VAL_W-1:0] val_q [NODE_NUM];
    logic [TBL_AW-1:0] i_q, i_nx;
    logic [GAIN_W-1:0] gain_nx;
    logic [DIV_CYC-1:0] q;
    logic last, found, wr_ok, hit, div_start, div_done, load;

    assign IN_READY  = state_q == IDLE;
    assign OUT_VALID = state_q == OUT;
    assign BUSY      = state_q != IDLE;

    always_comb begin
        i_nx      = i_q + TBL_AW'(1);
        lo        = pos_q[i_q];
        hi        = pos_q[i_nx];
        w         = hi - lo;
        last      = i_q == LAST_SEG;
        found     = hi > x_q || last;
        cur       = seg_offset(x_q, lo, hi, last);
        gain_nx   = (w == '0) ? '0 : GAIN_W'(q - DIV_CYC'(1));
        wr_ok     = TBL_WE && state_q == IDLE && {1'b0, TBL_ADDR} < (TBL_AW + 1)'(NODE_NUM);
        div_start = state_q == SEARCH && found && w != '0;
        load      = (state_q == SEARCH && found && w == '0) || (state_q == DIV && div_done);
    end

    lod_recip_div u_div (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .start_i (div_start),
        .w_i     (w),
        .done_o  (div_done),
        .q_o     (q)
    );

`ifdef LOD_SEG_REUSE_EN
    logic c_valid_q;
    logic [TBL_AW-1:0] c_i_q;
    logic [POS_W-1:0] c_lo_q, c_hi_q;
    logic [GAIN_W-1:0] c_gain_q;
    logic [VAL_W-1:0] c_lv_q, c_rv_q;
    // A write in the handshake cycle already invalidates the cache for that job.
    assign hit = c_valid_q && !wr_ok && c_lo_q <= IN_X && IN_X < c_hi_q;
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            c_valid_q <= 1'b0;
            c_i_q     <= '0;
            c_lo_q    <= '0;
            c_hi_q    <= '0;
            c_gain_q  <= '0;
            c_lv_q    <= '0;
            c_rv_q    <= '0;
        end else if (wr_ok) begin
            c_valid_q <= 1'b0;
        end else if (load) begin
            c_valid_q <= 1'b1;
            c_i_q     <= i_q;
            c_lo_q    <= lo;
            c_hi_q    <= hi;
            c_gain_q  <= gain_nx;
            c_lv_q    <= val_q[i_q];
            c_rv_q    <= val_q[i_nx];
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q     <= IDLE;
            x_q         <= '0;
            i_q         <= '0;
            CURRENT     <= '0;
            GAIN        <= '0;
            LEFT_VALUE  <= '0;
            RIGHT_VALUE <= '0;
            for (int k = 0; k < NODE_NUM; k++) begin
                pos_q[k] <= '0;
                val_q[k] <= '0;
            end
        end else begin
            if (wr_ok) begin
                pos_q[TBL_ADDR] <= TBL_POS;
                val_q[TBL_ADDR] <= TBL_VAL;
            end
            case (state_q)
                IDLE: if (IN_VALID) begin
                    x_q     <= IN_X;
                    i_q     <= '0;
                    state_q <= hit ? OUT : SEARCH;
`ifdef LOD_SEG_REUSE_EN
                    if (hit) begin
                        i_q         <= c_i_q;
                        CURRENT     <= IN_X - c_lo_q;
                        GAIN        <= c_gain_q;
                        LEFT_VALUE  <= c_lv_q;
                        RIGHT_VALUE <= c_rv_q;
                    end
`endif
                end
                SEARCH: if (!found) i_q <= i_nx; else if (w != '0) state_q <= DIV;
                OUT: if (OUT_READY) state_q <= IDLE;
                default: ;
            endcase
            if (load) begin
                state_q     <= OUT;
                CURRENT     <= cur;
                GAIN        <= gain_nx;
                LEFT_VALUE  <= val_q[i_q];
                RIGHT_VALUE <= val_q[i_nx];
            end
        end
    end
endmodule

// File: tb/tb_lod_seg_locate.sv
// tb_lod_seg_locate: directed and randomized jobs checked against a table-scan reference model.
module tb_lod_seg_locate;
    localparam int N = 9;
    logic CLK = 1'b0, RSTB = 1'b1, TBL_WE = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b1;
    logic [3:0] TBL_ADDR = '0;
    logic [9:0] TBL_POS = '0, IN_X = '0;
    logic [7:0] TBL_VAL = '0;
    logic IN_READY, OUT_VALID, BUSY;
    logic [9:0] CURRENT;
    logic [11:0] GAIN;
    logic [7:0] LEFT_VALUE, RIGHT_VALUE;
    int n_cmp = 0, n_fail = 0;
    int mpos[N], mval[N];
    bit cv = 0;
    int clo, chi, cgain, clv, crv;
    int e_cur, e_gain, e_lv, e_rv, e_lat;

    lod_seg_locate #(.NODE_NUM(N), .TBL_AW(4)) dut (
        .CLK(CLK), .RSTB(RSTB), .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_POS(TBL_POS),
        .TBL_VAL(TBL_VAL), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_X(IN_X),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .CURRENT(CURRENT), .GAIN(GAIN),
        .LEFT_VALUE(LEFT_VALUE), .RIGHT_VALUE(RIGHT_VALUE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    // Reference: first segment whose right node lies beyond X, else the last one.
    task automatic predict(input int x);
        int seg, w;
`ifdef LOD_SEG_REUSE_EN
        if (cv && clo <= x && x < chi) begin
            e_cur = x - clo; e_gain = cgain; e_lv = clv; e_rv = crv; e_lat = 1;
            return;
        end
`endif
        seg = N - 2;
        for (int i = 0; i < N - 1; i++) if (mpos[i+1] > x) begin seg = i; break; end
        w = mpos[seg+1] - mpos[seg];
        e_lv = mval[seg];
        e_rv = mval[seg+1];
        if (w == 0) begin
            e_cur = 0; e_gain = 0; e_lat = seg + 2;
        end else begin
            e_gain = 4096 / w - 1;
            e_cur  = (x < mpos[seg]) ? 0 : (x >= mpos[seg+1]) ? w - 1 : x - mpos[seg];
            e_lat  = seg + 15;
        end
        cv = 1; clo = mpos[seg]; chi = mpos[seg+1]; cgain = e_gain; clv = e_lv; crv = e_rv;
    endtask

    task automatic wr(input int a, input int p, input int v);
        TBL_WE = 1'b1; TBL_ADDR = 4'(a); TBL_POS = 10'(p); TBL_VAL = 8'(v);
        step();
        TBL_WE = 1'b0;
        if (a < N) begin mpos[a] = p; mval[a] = v; cv = 0; end
    endtask

    task automatic launch(input string tag, input int x);
        int lat;
        predict(x);
        chk({tag, "_in_ready"}, IN_READY, 1);
        IN_X = 10'(x); IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 300) begin step(); lat++; end
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_current"}, CURRENT, e_cur);
        chk({tag, "_gain"}, GAIN, e_gain);
        chk({tag, "_left"}, LEFT_VALUE, e_lv);
        chk({tag, "_right"}, RIGHT_VALUE, e_rv);
        chk({tag, "_busy"}, BUSY, 1);
    endtask

    task automatic plan_table();
        for (int i = 0; i < 8; i++) wr(i, 128 * i, 32 * i);
        wr(8, 1023, 255);
    endtask

    initial begin
        int p, x, j;
        #2 RSTB = 1'b0;
        #10;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_current", CURRENT, 0);
        chk("rst_gain", GAIN, 0);
        chk("rst_left", LEFT_VALUE, 0);
        chk("rst_right", RIGHT_VALUE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_in_ready", IN_READY, 1);
        RSTB = 1'b1;
        step();
        launch("degenerate", 5); step();
        for (int i = 0; i < N; i++) wr(i, i, 3 * i);
        launch("w1", 0); step();
        plan_table();
        launch("x300", 300); step();
        launch("x1023", 1023); step();
        launch("x0", 0); step();
        launch("x300b", 300); step();
        launch("x310", 310); step();
        wr(5, 640, 160);
        launch("x310_after_wr", 310); step();
        // Downstream stall: outputs frozen and table writes ignored.
        OUT_READY = 1'b0;
        launch("bp", 300);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin TBL_WE = 1'b1; TBL_ADDR = 4'd2; TBL_POS = 10'd999; TBL_VAL = 8'd7; end
            step();
            TBL_WE = 1'b0;
            chk("bp_out_valid", OUT_VALID, 1);
            chk("bp_in_ready", IN_READY, 0);
            chk("bp_current", CURRENT, e_cur);
            chk("bp_gain", GAIN, e_gain);
            chk("bp_right", RIGHT_VALUE, e_rv);
        end
        OUT_READY = 1'b1;
        step();
        launch("bp_readback", 200); step();
        wr(12, 500, 9);
        for (int t = 0; t < 4; t++) begin
            p = $urandom_range(0, 100);
            for (int i = 0; i < N; i++) begin
                wr(i, p, $urandom_range(0, 255));
                p += ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 140);
                if (p > 1023) p = 1023;
            end
            for (int n = 0; n < 8; n++) begin
                if ($urandom_range(0, 1) == 1) x = $urandom_range(0, 1023);
                else begin
                    j = $urandom_range(0, N - 1);
                    x = mpos[j] + int'($urandom_range(0, 2)) - 1;
                    x = (x < 0) ? 0 : (x > 1023) ? 1023 : x;
                end
                OUT_READY = 1'($urandom_range(0, 1));
                launch("rand", x);
                if (!OUT_READY) begin
                    repeat ($urandom_range(0, 3)) step();
                    chk("rand_hold_valid", OUT_VALID, 1);
                    OUT_READY = 1'b1;
                end
                step();
            end
        end
        // Reset in the middle of a division abandons the job.
        plan_table();
        IN_X = 10'd300; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        repeat (8) step();
        chk("mid_div_busy", BUSY, 1);
        RSTB = 1'b0;
        #1;
        chk("mid_rst_out_valid", OUT_VALID, 0);
        chk("mid_rst_in_ready", IN_READY, 1);
        step();
        RSTB = 1'b1;
        for (int i = 0; i < N; i++) begin mpos[i] = 0; mval[i] = 0; end
        cv = 0;
        repeat (20) step();
        chk("post_rst_out_valid", OUT_VALID, 0);
        chk("post_rst_in_ready", IN_READY, 1);
        launch("post_rst", 5); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
